// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, RV32I funct3 codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Encoding 2'b11 is never legal, so folding it into word size is harmless.
    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = SZ_BYTE;
            2'b01:   size_of = SZ_HALF;
            default: size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            funct3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            funct3_legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                           (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, load extension, misalignment.
// With LSU_MISALIGN_TRAP_EN unaligned half/word accesses flag; otherwise the offset is masked per size.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    lsu_size_e   size;
    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        size       = size_of(funct3);
        off        = offset;
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (size)
            SZ_HALF: misaligned = offset[0];
            SZ_WORD: misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
`else
        case (size)
            SZ_HALF: off = {offset[1], 1'b0};
            SZ_WORD: off = 2'b00;
            default: off = offset;
        endcase
`endif
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << off;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
        endcase

        // funct3[2] marks the unsigned load variants.
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: load_data = {{24{shifted[7]  & ~funct3[2]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage LSU running one memory op at a time; LSU_MISALIGN_TRAP_EN enables misalignment faults.
// Latency: fault 1, store 2, load 3 cycles minimum; stalls on mem_ready_i / mem_rvalid_i, req_ready_o low while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              done_o,
    output logic              fault_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o
);

    lsu_state_e  state, state_nxt;
    logic        we_q, fault_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;

    logic        accept, acc_fault;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_mis;

    assign req_ready_o = (state == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;

    // One aligner serves both directions: live request fields while idle, latched fields afterwards.
    assign al_funct3 = req_ready_o ? req_funct3_i    : funct3_q;
    assign al_off    = req_ready_o ? req_addr_i[1:0] : off_q;

    lsu_align u_align (
        .funct3     (al_funct3),
        .offset     (al_off),
        .wdata      (req_wdata_i),
        .rdata      (mem_rdata_i),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .misaligned (al_mis),
        .load_data  (al_load)
    );

    assign acc_fault = !funct3_legal(req_we_i, req_funct3_i) || al_mis;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)       state_nxt = acc_fault ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_ready_i)  state_nxt = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT: if (mem_rvalid_i) state_nxt = ST_RESP;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= 32'd0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            data_q      <= 32'd0;
        end else begin
            mem_valid_o <= (state_nxt == ST_REQ);
            if (accept) begin
                we_q     <= req_we_i;
                fault_q  <= acc_fault;
                funct3_q <= req_funct3_i;
                off_q    <= req_addr_i[1:0];
                rd_q     <= req_rd_i;
                data_q   <= 32'd0;
                if (!acc_fault) begin
                    mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                    mem_we_o    <= req_we_i;
                    mem_be_o    <= al_be;
                    mem_wdata_o <= al_wdata;
                end
            end
            if ((state == ST_WAIT) && mem_rvalid_i)
                data_q <= al_load;
        end
    end

    assign done_o    = (state == ST_RESP);
    assign fault_o   = done_o & fault_q;
    assign wb_we_o   = done_o & ~we_q & ~fault_q;
    assign wb_rd_o   = rd_q;
    assign wb_data_o = data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Execute-stage load/store unit; sits directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Runs one data-memory transaction at a time through a valid/ready request and a response-valid channel.
- Returns sign/zero-extended load data to writeback, and raises a fault for illegal or misaligned accesses.

## Interface
- `ADDR_W`, 32: effective address width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: EX presents a memory op.
- `req_ready_o` out 1: unit idle, accepts request.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I width/sign encoding.
- `req_addr_i` in ADDR_W: effective address (ALU output).
- `req_wdata_i` in 32: rs2 value.
- `req_rd_i` in 5: load destination register.
- `mem_valid_o` out 1: memory request valid.
- `mem_ready_i` in 1: memory accepts request.
- `mem_addr_o` out ADDR_W: word-aligned address, `[1:0]` = 0.
- `mem_we_o` out 1: write strobe.
- `mem_be_o` out 4: byte enables.
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_rvalid_i` in 1: load data valid.
- `mem_rdata_i` in 32: load word.
- `done_o` out 1: one-cycle completion pulse.
- `fault_o` out 1: qualifies `done_o`; access faulted.
- `wb_we_o` out 1: one-cycle register-write pulse (loads only).
- `wb_rd_o` out 5: destination register.
- `wb_data_o` out 32: extended load data.

## Operation
- **States:** IDLE, REQ, WAIT, RESP.
- **Reset:** state IDLE; every output and internal register 0.
- **Accept:** `req_ready_o` = (state == IDLE). Accept on `req_valid_i & req_ready_o`; register addr, we, funct3, rd, wdata.
- **Funct3 legality:**
  - Loads legal: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores legal: 000 SB, 001 SH, 010 SW.
  - Anything else is a fault, independent of configuration.
- **Byte enables**, with `o` = `addr[1:0]`:
  - byte: 0001 << o
  - half: 0011 << o
  - word: 1111
- **Store data:** SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- **Load extract:** `mem_rdata_i >> (8*o)`; low byte/half sign-extended (LB/LH) or zero-extended (LBU/LHU).
- **IDLE -> REQ** on a legal accept. A faulting accept goes to RESP with fault set and issues no memory request.
- **REQ:** `mem_valid_o` = 1 with addr/we/be/wdata held stable until `mem_ready_i`.
  - Store: go to RESP.
  - Load: go to WAIT.
- **WAIT:** on `mem_rvalid_i`, capture extracted data and go to RESP. `mem_rvalid_i` in any other state is ignored.
- **RESP:** `done_o` = 1 for one cycle.
  - Load: `wb_we_o` = 1 with `wb_rd_o` and `wb_data_o`.
  - Fault: `fault_o` = 1 and `wb_we_o` = 0.
  - Next state IDLE.
- **rd = 0:** `wb_we_o` is still pulsed; the register file discards it.
- **Reset mid-operation:** abort to IDLE; `mem_valid_o` drops immediately. A stale `mem_rvalid_i` after reset is ignored.

## Timing
- Accept edge T0 -> `mem_valid_o` high from T0+1.
- Store, `mem_ready_i` high at T0+1: `done_o` at T0+2. Minimum store latency 2 cycles.
- Load, ready at T0+1, rvalid at T0+2: `wb_we_o`/`done_o` at T0+3. Minimum load latency 3 cycles.
- Fault: `done_o` + `fault_o` at T0+1.
- Throughput: one op per (latency + 1) cycles; the next accept is earliest in the cycle after RESP.
- `mem_*` outputs are registered. `req_ready_o` is decoded from registered state only (no combinational path from `req_valid_i`).

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Halfword access with `addr[0]` = 1 faults.
  - Word access with `addr[1:0]` ≠ 0 faults.
  - A faulting access issues no memory request; `done_o` + `fault_o` at T0+1.
- **Undefined:**
  - No misalignment check.
  - Offset masked per size: half uses `{addr[1],1'b0}`; word uses 00.
  - The access proceeds normally; only illegal funct3 faults.

## Structure
- Shared package `lsu_pkg`:
  - state enum `lsu_state_e`.
  - funct3 constants `F3_LB`..`F3_LHU`, `F3_SB`..`F3_SW`.
  - access-size enum.
- Sub-module `lsu_align` (combinational):
  - funct3 + offset + wdata -> be, lane data, misaligned flag.
  - funct3 + offset + rdata -> extended load value.

## Test plan
- Reset values: assert `rst_i` -> all outputs 0, `req_ready_o` = 1 after release.
- Store SB, addr 0x1003, wdata 0x000000AB, ready immediate:
  - `mem_addr_o` = 0x1000, be = 1000, wdata = 0xABABABAB.
  - `done_o` at T0+2, `wb_we_o` = 0.
- Load LB then LBU, addr 0x2002, rdata 0x12F03456 (one op each):
  - LB: `wb_data_o` = 0xFFFFFFF0.
  - LBU: `wb_data_o` = 0x000000F0.
  - rd echoed; done at T0+3.
- Backpressure: `mem_ready_i` low 3 cycles on LW 0x40 -> request fields stable throughout; `req_ready_o` = 0 until after RESP.
- LH at 0x101:
  - With `LSU_MISALIGN_TRAP_EN`: `fault_o` + `done_o` at T0+1, no `mem_valid_o`.
  - Without it: be = 0011 at 0x100, normal completion.
- Illegal funct3 011 on a load -> fault in both configurations. Reset asserted during WAIT -> IDLE, and a later rvalid produces no `wb_we_o`.
